// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals shared by the UART TX arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the transmitter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]         req_valid;
  logic [8*N_REQ-1:0]       req_data;
  logic [N_REQ-1:0]         req_last;
  logic [N_REQ-1:0]         req_ready;
  logic                     tx_start;
  logic [7:0]               tx_data;
  logic                     tx_done;
  logic [$clog2(N_REQ)-1:0] grant_id;
  logic                     busy;

  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_start, tx_data, grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte streams,
// with per-message grant locking and a hold timeout for stalled messages.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned HOLD_TIMEOUT = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_arbiter_if.slave      bus
);
  localparam int unsigned IDW     = $clog2(N_REQ);
  localparam int unsigned CW      = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam int unsigned HT_LAST = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    HOLD
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   grant_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic             last_q;
  logic [CW-1:0]    cnt_q;

  logic [7:0]       bytes [N_REQ];
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  int unsigned      idx;
  logic [N_REQ-1:0] ready;
  logic [IDW-1:0]   sel_idx;
  logic             xfer;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      bytes[i] = bus.req_data[8*i +: 8];
    end
  end

  // Search starts one past the last winner and wraps, so the previous owner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    ready   = '0;
    sel_idx = grant_q;
    if (state_q == IDLE) begin
      sel_idx = win_idx;
      if (win_found) ready[win_idx] = 1'b1;
    end else if (state_q == HOLD) begin
      ready[grant_q] = 1'b1;
    end
  end

  assign xfer = |(bus.req_valid & ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IDW'(N_REQ - 1);
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            tx_data_q  <= bytes[sel_idx];
            last_q     <= bus.req_last[sel_idx];
            grant_q    <= win_idx;
            ptr_q      <= win_idx;
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: state_q <= WAIT;
        WAIT: begin
          if (bus.tx_done) begin
            if (last_q || HOLD_TIMEOUT == 0) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= '0;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          // A transfer wins over timeout expiry in the same cycle.
          if (xfer) begin
            tx_data_q  <= bytes[sel_idx];
            last_q     <= bus.req_last[sel_idx];
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end else if (cnt_q == CW'(HT_LAST)) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin order, message locking,
// hold timeout, launch latency, spurious done pulses and reset mid-job.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .HOLD_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_tx_start(input int budget, output logic seen, output logic [7:0] d);
    seen = 1'b0;
    d    = '0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.tx_start) begin
        seen = 1'b1;
        d    = bus.tx_data;
      end
    end
  endtask

  task automatic pulse_done(input int delay);
    repeat (delay) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start got=%b exp=0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    checks++; if (bus.grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_id); end
    checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_b [5];
    logic       seen;
    logic [7:0] d;
    int         extra;
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43; exp_b[3] = 8'h44; exp_b[4] = 8'h41;
    do_reset();
    bus.req_data  = {8'h44, 8'h43, 8'h42, 8'h41};
    bus.req_last  = 4'b1111;
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_tx_start(30, seen, d);
      checks++; if (seen !== 1'b1) begin fails++; $display("FAIL rr_start_seen n=%0d got=%b exp=1", n, seen); end
      checks++; if (d !== exp_b[n]) begin fails++; $display("FAIL rr_data n=%0d got=%h exp=%h", n, d, exp_b[n]); end
      checks++; if (bus.grant_id !== 2'(n % 4)) begin fails++; $display("FAIL rr_grant n=%0d got=%0d exp=%0d", n, bus.grant_id, n % 4); end
      extra = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (bus.tx_start) extra++;
      end
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      checks++; if (extra !== 0) begin fails++; $display("FAIL rr_single_start n=%0d got=%0d exp=0", n, extra); end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_latency();
    do_reset();
    bus.req_data  = {8'h00, 8'h5A, 8'h00, 8'h00};
    bus.req_last  = 4'b0100;
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL lat_ready_same_cycle got=%b exp=0100", bus.req_ready); end
    tick();
    checks++; if (bus.tx_start !== 1'b1) begin fails++; $display("FAIL lat_start_k1 got=%b exp=1", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h5A) begin fails++; $display("FAIL lat_data got=%h exp=5a", bus.tx_data); end
    checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL lat_ready_launch got=%b exp=0000", bus.req_ready); end
    bus.req_valid = 4'b0101;
    bus.req_data  = {8'h00, 8'h77, 8'h00, 8'h66};
    tick();
    checks++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL lat_start_one_cycle got=%b exp=0", bus.tx_start); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (bus.tx_data !== 8'h5A || bus.req_ready !== 4'b0000) begin
        fails++; $display("FAIL lat_wait_stable c=%0d data=%h ready=%b exp data=5a ready=0000", c, bus.tx_data, bus.req_ready);
      end
      tick();
    end
    bus.req_valid = '0;
    pulse_done(0);
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL lat_idle_after_done got=%b exp=0", bus.busy); end
  endtask

  task automatic test_hold_lock();
    logic       seen;
    logic [7:0] d;
    do_reset();
    bus.req_data  = {8'h00, 8'h41, 8'h00, 8'h30};
    bus.req_last  = 4'b0001;
    bus.req_valid = 4'b0100;
    wait_tx_start(5, seen, d);
    checks++; if (d !== 8'h41 || seen !== 1'b1) begin fails++; $display("FAIL lock_A got=%h seen=%b exp=41", d, seen); end
    bus.req_data  = {8'h00, 8'h42, 8'h00, 8'h30};
    bus.req_valid = 4'b0101;
    pulse_done(10);
    checks++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL lock_hold_ready_B got=%b exp=0100", bus.req_ready); end
    wait_tx_start(5, seen, d);
    checks++; if (d !== 8'h42 || seen !== 1'b1) begin fails++; $display("FAIL lock_B got=%h seen=%b exp=42", d, seen); end
    bus.req_data = {8'h00, 8'h43, 8'h00, 8'h30};
    bus.req_last = 4'b0101;
    pulse_done(10);
    checks++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL lock_hold_ready_C got=%b exp=0100", bus.req_ready); end
    wait_tx_start(5, seen, d);
    checks++; if (d !== 8'h43 || bus.grant_id !== 2'd2) begin fails++; $display("FAIL lock_C got=%h grant=%0d exp=43 grant=2", d, bus.grant_id); end
    bus.req_valid = 4'b0001;
    pulse_done(10);
    wait_tx_start(5, seen, d);
    checks++; if (d !== 8'h30 || bus.grant_id !== 2'd0) begin fails++; $display("FAIL lock_req0_after got=%h grant=%0d exp=30 grant=0", d, bus.grant_id); end
    bus.req_valid = '0;
    pulse_done(10);
  endtask

  task automatic test_hold_timeout();
    logic       seen;
    logic [7:0] d;
    int         bad;
    do_reset();
    bus.req_data  = {8'h33, 8'h00, 8'h11, 8'h00};
    bus.req_last  = 4'b1000;
    bus.req_valid = 4'b1010;
    wait_tx_start(5, seen, d);
    checks++; if (d !== 8'h11 || bus.grant_id !== 2'd1) begin fails++; $display("FAIL to_first got=%h grant=%0d exp=11 grant=1", d, bus.grant_id); end
    bus.req_valid = 4'b1000;
    pulse_done(10);
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (bus.req_ready !== 4'b0010 || bus.busy !== 1'b1 || bus.tx_start !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL to_hold_window got=%0d bad cycles exp=0", bad); end
    checks++; if (bus.req_ready !== 4'b1000 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL to_release got ready=%b busy=%b exp ready=1000 busy=0", bus.req_ready, bus.busy);
    end
    tick();
    checks++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h33 || bus.grant_id !== 2'd3) begin
      fails++; $display("FAIL to_req3 got start=%b data=%h grant=%0d exp 1/33/3", bus.tx_start, bus.tx_data, bus.grant_id);
    end
    bus.req_valid = '0;
    pulse_done(10);
  endtask

  task automatic test_spurious_done();
    logic       seen;
    logic [7:0] d;
    do_reset();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin
      fails++; $display("FAIL spur_idle got busy=%b start=%b exp 0/0", bus.busy, bus.tx_start);
    end
    bus.req_data  = {8'h00, 8'h00, 8'h21, 8'h00};
    bus.req_last  = 4'b0000;
    bus.req_valid = 4'b0010;
    wait_tx_start(5, seen, d);
    bus.req_valid = '0;
    pulse_done(10);
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0 || bus.req_ready !== 4'b0010) begin
      fails++; $display("FAIL spur_hold got busy=%b start=%b ready=%b exp 1/0/0010", bus.busy, bus.tx_start, bus.req_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    logic       seen;
    logic [7:0] d;
    do_reset();
    bus.req_data  = {8'h00, 8'h99, 8'h00, 8'h00};
    bus.req_last  = 4'b1111;
    bus.req_valid = 4'b0100;
    wait_tx_start(5, seen, d);
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0 || bus.grant_id !== 2'd0) begin
      fails++; $display("FAIL rstwait got busy=%b start=%b grant=%0d exp 0/0/0", bus.busy, bus.tx_start, bus.grant_id);
    end
    pulse_done(3);
    checks++; if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin
      fails++; $display("FAIL rstwait_late_done got busy=%b start=%b exp 0/0", bus.busy, bus.tx_start);
    end
    bus.req_data  = {8'hD0, 8'h00, 8'h00, 8'hA0};
    bus.req_valid = 4'b1001;
    wait_tx_start(5, seen, d);
    checks++; if (d !== 8'hA0 || bus.grant_id !== 2'd0) begin
      fails++; $display("FAIL rstwait_winner got data=%h grant=%0d exp A0/0", d, bus.grant_id);
    end
    bus.req_valid = '0;
    pulse_done(10);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;
    test_reset();
    test_round_robin();
    test_latency();
    test_hold_lock();
    test_hold_timeout();
    test_spurious_done();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N_REQ byte-stream requesters, e.g. command echo, status reporter and debug logger.
- Selects the next requester by round-robin and issues one byte per transmitter job as a start/data command.
- Waits for the transmitter's done pulse before issuing the next job.
- Supports message locking: a requester keeps the grant until it marks its last byte, or until the hold times out.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_TIMEOUT, 20000, clk cycles the grant is held for an incomplete message waiting for its next byte; 0 means release immediately after every byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester byte available.
- req_data  in  8*N_REQ  byte of requester i on bits [8i+7:8i].
- req_last  in  N_REQ  byte is the final byte of the message.
- req_ready  out  N_REQ  byte accepted; transfer occurs when valid&ready in the same cycle.
- tx_start  out  1  one-cycle pulse that launches a transmitter job.
- tx_data  out  8  byte for the transmitter; stable from the tx_start cycle until tx_done.
- tx_done  in  1  one-cycle pulse: transmitter finished the stop bit.
- grant_id  out  clog2(N_REQ)  index of the current or last owner.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE; tx_start=0; tx_data=0; req_ready=0; grant_id=0; busy=0; timeout counter=0; round-robin pointer=N_REQ-1, so requester 0 wins first.
- States: IDLE, LAUNCH, WAIT, HOLD.
- IDLE:
  - Winner = first i with req_valid[i] set, searching from pointer+1 with wrap.
  - req_ready[winner]=1 combinationally in the same cycle.
  - On transfer: latch data into tx_data, grant_id<=winner, latch last flag, pointer<=winner, go LAUNCH.
  - No valid request: stay in IDLE.
- LAUNCH: tx_start=1 for exactly one cycle, then go WAIT.
- WAIT:
  - On tx_done: if latched last=1 or HOLD_TIMEOUT=0, go IDLE; otherwise clear the counter and go HOLD.
  - No timeout applies in WAIT; the transmitter is trusted to complete.
- HOLD:
  - req_ready[grant_id]=1 only; all other requesters are blocked.
  - Transfer: latch data and last flag, go LAUNCH.
  - Otherwise the counter increments; at HOLD_TIMEOUT-1 without a transfer, go IDLE (message abandoned, grant released).
- Latency:
  - Transfer in cycle k gives tx_start in cycle k+1.
  - tx_done in cycle m gives the earliest next transfer in cycle m+1 (HOLD, or IDLE if released) and tx_start in cycle m+2.
- req_ready is never asserted in LAUNCH or WAIT; at most one bit is set at any time.
- tx_done outside WAIT is ignored and causes no state change.
- Requester valid deasserted after a loss: no effect; arbitration is re-evaluated every IDLE cycle.
- Single requester: wins every round; the pointer still updates.
- Round-robin fairness: with all requesters continuously valid and single-byte messages, grant order is 0,1,2,3,0,...
- rst in any state returns everything to the reset values in the next cycle. A transmitter job already in flight is not aborted by this block, and its later tx_done is ignored.
- Simultaneous in HOLD: transfer and timeout expiry in the same cycle gives priority to the transfer.

Test Plan:
- After reset, req_valid=4'b1111, all req_last=1, distinct bytes 0x41..0x44, tx_done pulsed 10 cycles after each tx_start -> tx_data order 0x41,0x42,0x43,0x44,0x41; exactly one tx_start per byte.
- Requester 2 sends "ABC" (last on 'C') while requester 0 is valid throughout -> tx bytes 'A','B','C' then req0's byte; req_ready[0] stays 0 during HOLD.
- Requester 1 sends byte with last=0 then goes silent, HOLD_TIMEOUT=16 -> release 16 cycles after tx_done; pending requester 3 is accepted in the next cycle.
- Valid at cycle k in IDLE -> req_ready same cycle, tx_start at k+1 for one cycle, tx_data unchanged until tx_done.
- Spurious tx_done in IDLE and HOLD -> no state change, no tx_start.
- rst asserted in WAIT -> next cycle busy=0, tx_start=0, grant_id=0; then requesters 0 and 3 both valid -> 0 wins.
